// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// standard or first-word-fall-through read mode, sticky error flags and flush.
module fifo_sync_prog #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH - 1) begin : g_bad_param
    $error("fifo_sync_prog: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Status decodes straight from the count register
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // Flush masks both requests; a full FIFO never writes through a same-cycle read
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented continuously; rd_en acts as the pop acknowledge
    assign data_out = mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         data_out <= '0;
      else if (flush)  data_out <= '0;
      else if (rd_acc) data_out <= mem[rd_ptr];
    end
  end

endmodule
